spi_note_receiver: RTL and testbench
====================================

Name: spi_note_receiver

Overview:
- SPI slave front end that receives voice/note update frames from the host MCU and turns them into single-cycle update strobes for the DDS voice engine.
- It drives the DDS update interface directly: o_SPI_flag, o_SPI_midi_note and o_SPI_voice_index.
- It synchronises the asynchronous SPI pins, assembles 16-bit frames and validates them.
- Valid frames are buffered in a small FIFO and released at a paced rate, so the DDS single-entry update buffer is never re-strobed while it is still busy.

Parameters:
- FIFO_DEPTH, 4, frame FIFO entries; power of 2, at least 2.
- GAP_CYCLES, 8, minimum i_clk cycles from one o_SPI_flag pulse to the next; at least 1.
- SYNC_STAGES, 2, flip-flop stages on each SPI input; at least 2.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_spi_sck  in  1  SPI clock, mode 0, asynchronous to i_clk.
- i_spi_cs_n  in  1  chip select, active low, asynchronous.
- i_spi_mosi  in  1  serial data in, MSB first.
- o_spi_miso  out  1  status byte out during byte 0.
- o_SPI_flag  out  1  one-cycle strobe: a new update is valid.
- o_SPI_midi_note  out  7  MIDI note of the current update.
- o_SPI_voice_index  out  8  target voice of the current update.
- o_fifo_level  out  clog2(FIFO_DEPTH)+1  number of entries in the FIFO.
- o_overflow  out  1  sticky: a frame was dropped because the FIFO was full.
- o_frame_error  out  1  sticky: a frame was aborted or malformed.

Behaviour:
- Reset:
  - All outputs are 0.
  - FIFO is empty, bit counter is 0, gap counter is 0.
  - Synchroniser flops are set to the idle pin levels: sck=0, cs_n=1, mosi=0.
  - Reset asserted mid-frame discards the partial frame; no strobe and no error result from it.
- Input sync and edge detection:
  - sck, cs_n and mosi each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronised signals, using one extra delay flop.
  - i_spi_sck must stay at or below i_clk/8.
- Frame format, 16 bits, MSB first:
  - Byte 0 is voice_index[7:0].
  - Byte 1 is {1'b0, midi_note[6:0]}.
- Receive state machine:
  - IDLE to SHIFT on a synchronised cs_n falling edge. This clears the bit counter and loads the status shift register.
  - In SHIFT, each synchronised sck rising edge samples mosi into the shift register and increments the bit counter.
  - When the bit counter reaches 16, go to COMMIT.
  - COMMIT lasts one cycle:
    - If byte1[7]=1: drop the frame and set o_frame_error.
    - Else if the FIFO is full and no pop occurs this cycle: drop the frame and set o_overflow.
    - Otherwise push {voice_index, note} into the FIFO.
  - After COMMIT, go to WAIT_CS. Further sck edges are ignored until cs_n rises, then return to IDLE.
  - A cs_n rising edge in SHIFT with a bit count of 1 to 15 discards the frame, sets o_frame_error and returns to IDLE.
  - A cs_n rising edge in SHIFT with a bit count of 0 returns to IDLE with no error.
  - A cs_n fall followed by a rise with no bits is a no-op.
  - A new cs_n falling edge in any state restarts the frame.
- MISO:
  - On cs_n fall, the status register loads {o_overflow, o_frame_error, 2'b00, o_fifo_level padded or truncated to 4 bits}.
  - o_spi_miso drives the status MSB and shifts left on each synchronised sck falling edge while the bit count is 1 to 7.
  - o_spi_miso is 0 for bits 8 to 15 and when idle.
- FIFO:
  - Circular buffer with wrapping read and write pointers.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full or empty.
  - When empty, a push made in cycle N is poppable in cycle N+1 at the earliest.
- Output pacing:
  - The gap counter decrements to 0 and saturates there.
  - When the FIFO is non-empty and the gap counter is 0, pop: o_SPI_flag=1 for exactly one cycle, the note and voice outputs are loaded in that same cycle, and the gap counter is loaded with GAP_CYCLES-1.
  - With GAP_CYCLES=1, strobes can occur back to back.
  - o_SPI_midi_note and o_SPI_voice_index hold their value until the next pop.
- Latency: the 16th synchronised sck rise is detected in cycle D. COMMIT occurs in D+1. With an empty FIFO and expired gap counter, the strobe occurs in D+2.
- Sticky flags: o_overflow and o_frame_error clear only on reset.

Test Plan:
- Single frame: send voice 0x05 and note 0x3C → exactly one o_SPI_flag pulse with o_SPI_voice_index=5 and o_SPI_midi_note=60; o_fifo_level returns to 0.
- Pacing: with GAP_CYCLES=8, send 3 frames back to back (voices 1, 2, 3) → 3 pulses in order, with rising cycles exactly 8 apart once queued; no flag flags set.
- Overflow: with GAP_CYCLES=1000 and FIFO_DEPTH=4, send 6 frames with an sck period of 8 clocks → the first is strobed, the next 4 are queued, the 6th is dropped and o_overflow=1. Remaining strobes appear 1000 cycles apart carrying voices 2 to 5.
- Abort and malformed frames:
  - cs_n rises after 9 bits → no pulse, o_frame_error=1.
  - Sending byte1=0x80 → no pulse.
  - A following valid frame is still delivered.
- Status readback: after an overflow with 2 entries queued, a new frame's first 8 MISO bits read 0x82.
- Reset mid-frame: assert i_reset after 10 bits → no pulse, all flags 0; the next full frame (voice 0x7F, note 0x00) is delivered correctly.

Source files
------------

// File: rtl/spi_note_receiver.sv
// SPI mode-0 slave that receives 16-bit voice/note frames and releases them to the
// DDS update interface as paced single-cycle strobes through a small frame FIFO.
module spi_note_receiver #(
  parameter int FIFO_DEPTH  = 4,
  parameter int GAP_CYCLES  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_spi_sck,
  input  logic                          i_spi_cs_n,
  input  logic                          i_spi_mosi,
  output logic                          o_spi_miso,
  output logic                          o_SPI_flag,
  output logic [6:0]                    o_SPI_midi_note,
  output logic [7:0]                    o_SPI_voice_index,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_overflow,
  output logic                          o_frame_error
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, WAIT_CS} state_t;

  // synchronisers, reset to the idle pin levels so reset never fabricates an edge
  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic sck_d, cs_d;
  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_fall, cs_rise;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], i_spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
      sck_d     <= sck_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign cs_rise  = cs_s & ~cs_d;

  state_t      state, state_next;
  logic [4:0]  bit_cnt;
  logic [15:0] shreg;
  logic [7:0]  status;
  logic        abort;
  logic        commit, bad_frame;

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    abort      = 1'b0;
    if (cs_fall) state_next = SHIFT;
    else begin
      case (state)
        SHIFT: begin
          if (cs_rise) begin
            state_next = IDLE;
            abort      = (bit_cnt != 5'd0);
          end else if (sck_rise && bit_cnt == 5'd15) begin
            state_next = COMMIT;
          end
        end
        COMMIT:  state_next = cs_rise ? IDLE : WAIT_CS;
        WAIT_CS: if (cs_rise) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign commit    = (state == COMMIT);
  assign bad_frame = shreg[7];

  // FIFO and pacing
  logic [14:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [LW-1:0] count;
  logic [GW-1:0] gap;
  logic          full, push, pop;
  logic [14:0]   head;
  logic [7:0]    voice_q;
  logic [6:0]    note_q;
  logic [LW+3:0] level_ext;

  assign full      = (count == LW'(FIFO_DEPTH));
  assign pop       = !i_reset && (count != '0) && (gap == '0);
  assign push      = commit && !bad_frame && (!full || pop);
  assign head      = mem[rptr];
  assign level_ext = {4'b0000, count};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bit_cnt       <= '0;
      shreg         <= '0;
      status        <= '0;
      o_overflow    <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      if (cs_fall) begin
        bit_cnt <= '0;
        status  <= {o_overflow, o_frame_error, 2'b00, level_ext[3:0]};
      end else if (state == SHIFT && !cs_rise) begin
        if (sck_rise) begin
          shreg   <= {shreg[14:0], mosi_s};
          bit_cnt <= bit_cnt + 5'd1;
        end
        if (sck_fall && bit_cnt != 5'd0 && bit_cnt < 5'd8)
          status <= {status[6:0], 1'b0};
      end
      if (abort || (commit && bad_frame)) o_frame_error <= 1'b1;
      if (commit && !bad_frame && full && !pop) o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wptr] <= {shreg[15:8], shreg[6:0]};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      gap     <= '0;
      voice_q <= '0;
      note_q  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr    <= rptr + 1'b1;
        voice_q <= head[14:7];
        note_q  <= head[6:0];
        gap     <= GW'(GAP_CYCLES - 1);
      end else if (gap != '0) begin
        gap <= gap - 1'b1;
      end
      count <= count + LW'(push) - LW'(pop);
    end
  end

  // the strobe and its payload appear in the pop cycle; payload then holds
  assign o_SPI_flag        = pop;
  assign o_SPI_voice_index = pop ? head[14:7] : voice_q;
  assign o_SPI_midi_note   = pop ? head[6:0] : note_q;
  assign o_fifo_level      = count;
  assign o_spi_miso        = (state == SHIFT && bit_cnt < 5'd8) ? status[7] : 1'b0;
endmodule

// File: tb/tb_spi_note_receiver.sv
// Self-checking bench: two receivers (fast and slow pacing) share the SPI bus with
// separate chip selects; strobes are logged and compared against a frame-level model.
module tb_spi_note_receiver;
  logic clk = 1'b0, rst = 1'b1, sck = 1'b0, mosi = 1'b0, cs_a = 1'b1, cs_b = 1'b1;
  logic miso_a, flag_a, ovf_a, ferr_a, miso_b, flag_b, ovf_b, ferr_b;
  logic [6:0] note_a, note_b;
  logic [7:0] voice_a, voice_b;
  logic [2:0] lvl_a, lvl_b;
  int cyc = 0;
  int checks = 0, errors = 0;

  typedef struct {int c; logic [7:0] v; logic [6:0] n;} ev_t;
  ev_t qa[$], qb[$];

  spi_note_receiver #(.FIFO_DEPTH(4), .GAP_CYCLES(8), .SYNC_STAGES(2)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_spi_sck(sck), .i_spi_cs_n(cs_a), .i_spi_mosi(mosi),
    .o_spi_miso(miso_a), .o_SPI_flag(flag_a), .o_SPI_midi_note(note_a),
    .o_SPI_voice_index(voice_a), .o_fifo_level(lvl_a), .o_overflow(ovf_a),
    .o_frame_error(ferr_a));

  spi_note_receiver #(.FIFO_DEPTH(4), .GAP_CYCLES(1000), .SYNC_STAGES(2)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_spi_sck(sck), .i_spi_cs_n(cs_b), .i_spi_mosi(mosi),
    .o_spi_miso(miso_b), .o_SPI_flag(flag_b), .o_SPI_midi_note(note_b),
    .o_SPI_voice_index(voice_b), .o_fifo_level(lvl_b), .o_overflow(ovf_b),
    .o_frame_error(ferr_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (flag_a) qa.push_back('{cyc, voice_a, note_a});
    if (flag_b) qb.push_back('{cyc, voice_b, note_b});
  end

  task automatic do_reset();
    rst = 1'b1; cs_a = 1'b1; cs_b = 1'b1; sck = 1'b0; mosi = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic set_cs(input logic which, input logic v);
    if (which) cs_b = v; else cs_a = v;
  endtask

  task automatic shift_bits(input logic which, input logic [15:0] d, input int n, input int half,
                            output logic [7:0] mb, output int rise_cyc);
    mb = '0; rise_cyc = 0;
    for (int i = 0; i < n; i++) begin
      mosi = d[15-i];
      repeat (half) @(posedge clk);
      #1;
      if (i < 8) mb[7-i] = which ? miso_b : miso_a;
      sck = 1'b1; rise_cyc = cyc;
      repeat (half) @(posedge clk);
      #1 sck = 1'b0;
    end
  endtask

  // n < 16 aborts the frame by raising cs_n early
  task automatic send_frame(input logic which, input logic [7:0] v, input logic [7:0] b1,
                            input int n, input int half, output logic [7:0] mb, output int rc);
    set_cs(which, 1'b0);
    repeat (6) @(posedge clk);
    #1 shift_bits(which, {v, b1}, n, half, mb, rc);
    repeat (half) @(posedge clk);
    #1 set_cs(which, 1'b1);
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input logic which, input int n, input int limit);
    for (int i = 0; i < limit; i++) begin
      if ((which ? qb.size() : qa.size()) >= n) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    checks += 8;
    if (flag_a !== 1'b0 || flag_b !== 1'b0) begin errors++; $display("FAIL reset_flag got %b%b exp 00", flag_a, flag_b); end
    if (lvl_a !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", lvl_a); end
    if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf_a); end
    if (ferr_a !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", ferr_a); end
    if (miso_a !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", miso_a); end
    if (note_a !== 7'd0) begin errors++; $display("FAIL reset_note got %0h exp 0", note_a); end
    if (voice_a !== 8'd0) begin errors++; $display("FAIL reset_voice got %0h exp 0", voice_a); end
    if (lvl_b !== 3'd0 || ovf_b !== 1'b0 || ferr_b !== 1'b0) begin
      errors++; $display("FAIL reset_b got lvl %0d ovf %b ferr %b exp 0 0 0", lvl_b, ovf_b, ferr_b);
    end
  endtask

  task automatic test_single();
    logic [7:0] mb; int rc;
    qa.delete();
    send_frame(1'b0, 8'h05, 8'h3C, 16, 4, mb, rc);
    wait_n(1'b0, 1, 100);
    repeat (20) @(posedge clk);
    #1;
    checks += 5;
    if (qa.size() != 1) begin errors++; $display("FAIL single_count got %0d exp 1", qa.size()); end
    else begin
      if (qa[0].v !== 8'h05 || qa[0].n !== 7'd60) begin
        errors++; $display("FAIL single_data got %0h/%0d exp 05/60", qa[0].v, qa[0].n);
      end
      if (qa[0].c - rc != 4) begin errors++; $display("FAIL single_latency got %0d exp 4", qa[0].c - rc); end
    end
    if (lvl_a !== 3'd0) begin errors++; $display("FAIL single_level got %0d exp 0", lvl_a); end
    if (voice_a !== 8'h05 || note_a !== 7'd60) begin
      errors++; $display("FAIL single_hold got %0h/%0d exp 05/60", voice_a, note_a);
    end
  endtask

  task automatic test_pacing();
    logic [7:0] mb; int rc; logic [6:0] notes [3];
    qa.delete();
    for (int i = 0; i < 3; i++) begin
      notes[i] = 7'($urandom_range(0, 127));
      send_frame(1'b0, 8'(i + 1), {1'b0, notes[i]}, 16, 4, mb, rc);
    end
    wait_n(1'b0, 3, 200);
    checks += 2;
    if (qa.size() != 3) begin errors++; $display("FAIL pacing_count got %0d exp 3", qa.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (qa[i].v !== 8'(i + 1) || qa[i].n !== notes[i]) begin
          errors++; $display("FAIL pacing_data[%0d] got %0h/%0h exp %0h/%0h", i, qa[i].v, qa[i].n, i + 1, notes[i]);
        end
        if (i > 0) begin
          checks++;
          if (qa[i].c - qa[i-1].c < 8) begin errors++; $display("FAIL pacing_gap got %0d exp >=8", qa[i].c - qa[i-1].c); end
        end
      end
    end
    if (ovf_a !== 1'b0 || ferr_a !== 1'b0) begin
      errors++; $display("FAIL pacing_flags got %b%b exp 00", ovf_a, ferr_a);
    end
  endtask

  task automatic test_abort();
    logic [7:0] mb; int rc;
    qa.delete();
    send_frame(1'b0, 8'h44, 8'h22, 9, 4, mb, rc);
    repeat (30) @(posedge clk);
    #1;
    checks += 2;
    if (qa.size() != 0) begin errors++; $display("FAIL abort_pulse got %0d exp 0", qa.size()); end
    if (ferr_a !== 1'b1) begin errors++; $display("FAIL abort_ferr got %b exp 1", ferr_a); end
    send_frame(1'b0, 8'h45, 8'h80, 16, 4, mb, rc);
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (qa.size() != 0) begin errors++; $display("FAIL malformed_pulse got %0d exp 0", qa.size()); end
    send_frame(1'b0, 8'h46, 8'h12, 16, 4, mb, rc);
    wait_n(1'b0, 1, 100);
    checks += 2;
    if (qa.size() != 1) begin errors++; $display("FAIL after_abort_count got %0d exp 1", qa.size()); end
    else if (qa[0].v !== 8'h46 || qa[0].n !== 7'h12) begin
      errors++; $display("FAIL after_abort_data got %0h/%0h exp 46/12", qa[0].v, qa[0].n);
    end
    if (ovf_a !== 1'b0) begin errors++; $display("FAIL abort_ovf got %b exp 0", ovf_a); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] mb; int rc;
    qa.delete();
    cs_a = 1'b0;
    repeat (6) @(posedge clk);
    #1 shift_bits(1'b0, 16'hA5C3, 10, 4, mb, rc);
    rst = 1'b1; cs_a = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checks += 3;
    if (qa.size() != 0) begin errors++; $display("FAIL rstmid_pulse got %0d exp 0", qa.size()); end
    if (ovf_a !== 1'b0 || ferr_a !== 1'b0) begin errors++; $display("FAIL rstmid_flags got %b%b exp 00", ovf_a, ferr_a); end
    if (voice_a !== 8'd0 || note_a !== 7'd0 || lvl_a !== 3'd0) begin
      errors++; $display("FAIL rstmid_outs got %0h/%0h/%0d exp 0/0/0", voice_a, note_a, lvl_a);
    end
    send_frame(1'b0, 8'h7F, 8'h00, 16, 4, mb, rc);
    wait_n(1'b0, 1, 100);
    checks += 2;
    if (qa.size() != 1) begin errors++; $display("FAIL rstmid_next_count got %0d exp 1", qa.size()); end
    else if (qa[0].v !== 8'h7F || qa[0].n !== 7'h00) begin
      errors++; $display("FAIL rstmid_next_data got %0h/%0h exp 7f/00", qa[0].v, qa[0].n);
    end
    if (ferr_a !== 1'b0) begin errors++; $display("FAIL rstmid_next_ferr got %b exp 0", ferr_a); end
  endtask

  // model: only complete frames with byte1[7]=0 produce strobes, in order
  task automatic test_random();
    logic [7:0] mb; int rc; ev_t exp_q[$]; logic exp_err; logic [7:0] v, b1;
    do_reset();
    qa.delete(); exp_err = 1'b0;
    for (int k = 0; k < 12; k++) begin
      int kind = $urandom_range(0, 3);
      int half = $urandom_range(4, 6);
      v = 8'($urandom); b1 = {1'b0, 7'($urandom)};
      if (kind == 0) begin
        send_frame(1'b0, v, b1, $urandom_range(1, 15), half, mb, rc);
        exp_err = 1'b1;
      end else if (kind == 1) begin
        send_frame(1'b0, v, b1 | 8'h80, 16, half, mb, rc);
        exp_err = 1'b1;
      end else begin
        send_frame(1'b0, v, b1, 16, half, mb, rc);
        exp_q.push_back('{0, v, b1[6:0]});
      end
    end
    repeat (40) @(posedge clk);
    #1;
    checks += 3;
    if (qa.size() != exp_q.size()) begin errors++; $display("FAIL random_count got %0d exp %0d", qa.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < qa.size(); i++) begin
        checks++;
        if (qa[i].v !== exp_q[i].v || qa[i].n !== exp_q[i].n) begin
          errors++; $display("FAIL random_data[%0d] got %0h/%0h exp %0h/%0h", i, qa[i].v, qa[i].n, exp_q[i].v, exp_q[i].n);
        end
      end
    end
    if (ferr_a !== exp_err) begin errors++; $display("FAIL random_ferr got %b exp %b", ferr_a, exp_err); end
    if (ovf_a !== 1'b0) begin errors++; $display("FAIL random_ovf got %b exp 0", ovf_a); end
  endtask

  task automatic test_overflow();
    logic [7:0] mb; int rc;
    logic [7:0] exp_v [6];
    qb.delete();
    for (int i = 1; i <= 6; i++) send_frame(1'b1, 8'(i), 8'(10 + i), 16, 4, mb, rc);
    checks += 3;
    if (ovf_b !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", ovf_b); end
    if (lvl_b !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d exp 4", lvl_b); end
    if (qb.size() != 1) begin errors++; $display("FAIL ovf_first got %0d strobes exp 1", qb.size()); end
    wait_n(1'b1, 3, 2500);
    checks += 2;
    if (qb.size() != 3) begin errors++; $display("FAIL ovf_wait got %0d exp 3", qb.size()); end
    if (lvl_b !== 3'd2) begin errors++; $display("FAIL ovf_level2 got %0d exp 2", lvl_b); end
    send_frame(1'b1, 8'h10, 8'h11, 16, 8, mb, rc);
    checks++;
    if (mb !== 8'h82) begin errors++; $display("FAIL status_readback got %0h exp 82", mb); end
    wait_n(1'b1, 6, 3500);
    exp_v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'h10};
    checks += 2;
    if (qb.size() != 6) begin errors++; $display("FAIL ovf_total got %0d exp 6", qb.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (qb[i].v !== exp_v[i]) begin errors++; $display("FAIL ovf_voice[%0d] got %0h exp %0h", i, qb[i].v, exp_v[i]); end
        if (i > 0) begin
          checks++;
          if (qb[i].c - qb[i-1].c != 1000) begin
            errors++; $display("FAIL ovf_gap[%0d] got %0d exp 1000", i, qb[i].c - qb[i-1].c);
          end
        end
      end
    end
    if (ferr_b !== 1'b0) begin errors++; $display("FAIL ovf_ferr got %b exp 0", ferr_b); end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_single();
    test_pacing();
    test_abort();
    test_reset_mid();
    test_random();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
